// File: rtl/fmul_issue_arb.sv
// Issue arbiter sharing one pipelined FP multiplier between NREQ requesters.
// Define FMUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module fmul_issue_arb #(
  parameter int NREQ = 2,
  parameter int LAT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_x1,
  input  logic [NREQ*32-1:0] req_x2,
  input  logic               flush,
  output logic [31:0]        mul_x1,
  output logic [31:0]        mul_x2,
  input  logic [31:0]        mul_y,
  output logic [NREQ-1:0]    res_valid,
  output logic [31:0]        res_y,
  output logic [3:0]         inflight
);
  localparam int IDW = $clog2(NREQ);

  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan_id;
  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];

`ifndef FMUL_ARB_FIXED_PRIO_EN
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [IDW-1:0] rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (grant_any)
      rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);
  end
`endif

  // First valid requester in scan order wins; flush suppresses issue entirely.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_id   = '0;
    if (!flush) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef FMUL_ARB_FIXED_PRIO_EN
        scan_id = IDW'(k);
`else
        scan_id = IDW'((32'(rr_ptr) + k) % NREQ);
`endif
        if (!grant_any && req_valid[scan_id]) begin
          grant_any = 1'b1;
          grant_idx = scan_id;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_x1    = '0;
    mul_x2    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_any && grant_idx == IDW'(i)) begin
        req_ready[i] = 1'b1;
        mul_x1       = req_x1[32*i +: 32];
        mul_x2       = req_x2[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int unsigned k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else if (flush) begin
      tag_v <= '0;
      for (int unsigned k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_idx;
      for (int unsigned k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    res_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      res_valid[i] = tag_v[LAT-1] && (tag_id[LAT-1] == IDW'(i));
  end

  assign res_y = mul_y;

  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < LAT; k++)
      inflight = inflight + 4'(tag_v[k]);
  end

endmodule
